shift_register: RTL and testbench
=================================

Name: shift_register

Overview:
- Parameterised parallel-load, bidirectional logical shift register; default width 8 bits.
- Holds, loads or shifts its contents every clock, as selected by a 2-bit mode input.
- Used as a generic datapath storage/serialisation element.
- Built structurally as one per-bit cell (4:1 mode mux feeding a D flip-flop), replicated WIDTH times.

Parameters:
- WIDTH, 8, register and data width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low; it clears the register.
- load  input  2  mode select: 00 hold, 01 parallel load, 10 shift right, 11 shift left.
- data_in  input  WIDTH  parallel load value.
- data_out  output  WIDTH  current register contents, driven directly from the flops.

Behaviour:
- All state changes occur on the rising edge of clk. There is no combinational path from any input to data_out.
- Reset:
  - If reset==0 at the edge, the register becomes 0, whatever the values of load and data_in.
  - Reset has priority over every mode.
  - Asserting reset mid-shift discards the contents. The next non-reset edge operates on 0.
- Modes (applied only when reset==1):
  - 00 hold: q <= q.
  - 01 parallel load: q <= data_in.
  - 10 shift right logical: q <= {1'b0, q[WIDTH-1:1]}. The LSB is discarded and 0 enters the MSB.
  - 11 shift left logical: q <= {q[WIDTH-2:0], 1'b0}. The MSB is discarded and 0 enters the LSB.
- Latency: exactly one clock from a mode/data sample to the updated data_out. Exactly one operation is performed per edge.
- A mode held for N cycles performs N shifts. After WIDTH consecutive shifts in either direction the register is all-zero and then stays 0 while shifting continues. Shifting 0 yields 0.
- The mode may change on any cycle; each edge uses only the mode sampled at that edge.
- data_in is ignored in every mode except 01.
- Before the first reset, data_out is undefined (X in simulation). No power-on initial value is required.
- Per-bit cell i mux inputs:
  - 00: q[i].
  - 01: data_in[i].
  - 10: q[i+1], or 0 for the MSB.
  - 11: q[i-1], or 0 for the LSB.

Decomposition:
- Shared package shift_register_pkg holds:
  - typedef shift_mode_t (2-bit enum);
  - constants MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHR=2'b10, MODE_SHL=2'b11.
- One sub-module, shift_register_cell: 4:1 mux plus D flip-flop with synchronous active-low clear.
  - Ports: clk, reset, sel[1:0], hold_d, load_d, right_d, left_d, q.
  - The top instantiates it WIDTH times with a generate loop. Boundary cells tie the missing neighbour input to 0.

Test Plan:
- Reset: reset=0 for 1 cycle with load=01 and data_in=0xFF -> data_out=0x00 (reset wins). Releasing with load=00 keeps 0x00.
- Load then hold: data_in=100 (0x64), load=01 for one edge -> data_out=0x64. Then load=00 for 3 edges -> data_out stays 0x64. Changing data_in during the hold has no effect.
- Shift right 10 cycles from 0x64, load=10 -> 0x32, 0x19, 0x0C, 0x06, 0x03, 0x01, 0x00, then 0x00 for the remaining cycles.
- Reload then shift left 10 cycles: load=01 (0x64), then load=11 -> 0xC8, 0x90, 0x20, 0x40, 0x80, 0x00, then 0x00 thereafter.
- Mode switching: load 0x81, then SHL -> 0x02, then SHR -> 0x01, then SHR -> 0x00. Confirms 0-fill at both ends and per-edge mode sampling.
- Reset mid-operation: load 0xAA, 2 SHL edges (0xA8), then reset=0 for one edge with load=11 -> 0x00. Release with load=01, data_in=0x5A -> 0x5A on the next edge.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared types for the shift_register slice.
// Mode encodings select the per-bit cell mux input.
package shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } shift_mode_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/shift_register_cell.sv
// One storage bit: 4:1 mode mux feeding a D flop
// with synchronous active-low clear.
module shift_register_cell
  import shift_register_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       hold_d,
  input  logic       load_d,
  input  logic       right_d,
  input  logic       left_d,
  output logic       q
);

  shift_mode_t mode;
  logic        d;

  assign mode = shift_mode_t'(sel);

  always_comb begin
    d = hold_d;
    unique case (mode)
      MODE_HOLD: d = hold_d;
      MODE_LOAD: d = load_d;
      MODE_SHR:  d = right_d;
      MODE_SHL:  d = left_d;
      default:   d = hold_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register.sv
// Parallel-load bidirectional logical shift register,
// built from WIDTH replicated mux+flop cells.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_d;
    logic left_d;

    // End cells have no outer neighbour: zero fills in.
    if (i == WIDTH - 1) begin : g_msb
      assign right_d = 1'b0;
    end else begin : g_rn
      assign right_d = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_d = 1'b0;
    end else begin : g_ln
      assign left_d = q[i-1];
    end

    shift_register_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .sel     (load),
      .hold_d  (q[i]),
      .load_d  (data_in[i]),
      .right_d (right_d),
      .left_d  (left_d),
      .q       (q[i])
    );
  end

  assign data_out = q;

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register with directed
// vectors and hand-computed expectations.
module tb_shift_register;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [1:0]   load;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];

  shift_register #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on negedge; the following posedge produces exp.
  task automatic step(input logic r, input logic [1:0] m,
                      input logic [W-1:0] d,
                      input logic [W-1:0] e);
    @(negedge clk);
    reset   = r;
    load    = m;
    data_in = d;
    exp_q.push_back(e);
    tag_q.push_back(nstep);
    nstep++;
  endtask

  // Monitor: each edge presents one result.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (data_out !== e) begin
        bad++;
        $display("FAIL step%0d: data_out=%h expected=%h",
                 t, data_out, e);
      end
    end
  end

  logic [W-1:0] shr_exp [10] = '{8'h32, 8'h19, 8'h0C,
    8'h06, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [W-1:0] shl_exp [10] = '{8'hC8, 8'h90, 8'h20,
    8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    reset   = 1'b1;
    load    = 2'b00;
    data_in = '0;

    // reset wins over load
    step(1'b0, 2'b01, 8'hFF, 8'h00);
    step(1'b1, 2'b00, 8'hFF, 8'h00);

    // load then hold, data_in ignored
    step(1'b1, 2'b01, 8'h64, 8'h64);
    step(1'b1, 2'b00, 8'hFF, 8'h64);
    step(1'b1, 2'b00, 8'h00, 8'h64);
    step(1'b1, 2'b00, 8'hAA, 8'h64);

    for (int i = 0; i < 10; i++)
      step(1'b1, 2'b10, 8'hFF, shr_exp[i]);

    step(1'b1, 2'b01, 8'h64, 8'h64);
    for (int i = 0; i < 10; i++)
      step(1'b1, 2'b11, 8'h5A, shl_exp[i]);

    // per-edge mode sampling, zero fill both ends
    step(1'b1, 2'b01, 8'h81, 8'h81);
    step(1'b1, 2'b11, 8'h00, 8'h02);
    step(1'b1, 2'b10, 8'hFF, 8'h01);
    step(1'b1, 2'b10, 8'hFF, 8'h00);

    // reset mid-shift discards contents
    step(1'b1, 2'b01, 8'hAA, 8'hAA);
    step(1'b1, 2'b11, 8'h00, 8'h54);
    step(1'b1, 2'b11, 8'h00, 8'hA8);
    step(1'b0, 2'b11, 8'hFF, 8'h00);
    step(1'b1, 2'b01, 8'h5A, 8'h5A);
    step(1'b0, 2'b01, 8'hFF, 8'h00);
    step(1'b1, 2'b10, 8'hFF, 8'h00);
    step(1'b1, 2'b01, 8'h01, 8'h01);
    step(1'b1, 2'b11, 8'hFF, 8'h02);

    step(1'b1, 2'b00, 8'h00, 8'h02);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
